cmd_arb: RTL and testbench

Arbiter and sequencer in front of the single command processor (cmd_proc) of the Knight. It grants the executor to one of two requesters, the remote UART command path or the tour move sequencer. It latches the winning 16-bit command and holds it until the executor has consumed and completed it. It then returns a completion ack to the tour sequencer or a response byte to the UART path.

---
 rtl/cmd_arb.sv | 158 +++++++++++++++
 tb/tb_cmd_arb.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_arb.sv
// cmd_arb: grants the single command executor to the UART path or the tour sequencer.
// Optional tour abort by UART opcode F is compiled in with `define CMD_ARB_ABORT_EN.
module cmd_arb #(
  parameter logic [7:0] RESP_ACK   = 8'hA5,
  parameter logic [7:0] RESP_ABORT = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] uart_cmd,
  input  logic        uart_cmd_rdy,
  output logic        clr_uart_cmd_rdy,
  input  logic [15:0] tour_cmd,
  input  logic        tour_cmd_rdy,
  output logic        tour_ack,
  input  logic        tour_go,
  input  logic        tour_done,
  output logic        tour_active,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        resp_snd
);

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned RESP_W = 8;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_U  = 3'd1,
    BUSY_U = 3'd2,
    GNT_T  = 3'd3,
    BUSY_T = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CMD_W-1:0]    cmd_nxt;
  logic [RESP_W-1:0]   resp_nxt;
  logic                cmd_rdy_nxt;
  logic                clr_uart_nxt;
  logic                tour_ack_nxt;
  logic                tour_active_nxt;
  logic                resp_snd_nxt;
  logic                resp_pend, resp_pend_nxt;
  logic                uart_done;
  logic                abort_req;
  logic                abort_fire;

  // UART abort opcode; the clr_uart_cmd_rdy term keeps the same request from being taken twice
`ifdef CMD_ARB_ABORT_EN
  assign abort_req = tour_active && !tour_done && uart_cmd_rdy && !clr_uart_cmd_rdy &&
                     (uart_cmd[CMD_W-1 -: OP_W] == OP_W'(4'hF));
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cmd              <= '0;
      cmd_rdy          <= 1'b0;
      clr_uart_cmd_rdy <= 1'b0;
      tour_ack         <= 1'b0;
      tour_active      <= 1'b0;
      resp             <= '0;
      resp_snd         <= 1'b0;
      resp_pend        <= 1'b0;
    end else begin
      state            <= state_nxt;
      cmd              <= cmd_nxt;
      cmd_rdy          <= cmd_rdy_nxt;
      clr_uart_cmd_rdy <= clr_uart_nxt;
      tour_ack         <= tour_ack_nxt;
      tour_active      <= tour_active_nxt;
      resp             <= resp_nxt;
      resp_snd         <= resp_snd_nxt;
      resp_pend        <= resp_pend_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cmd_nxt         = cmd;
    cmd_rdy_nxt     = cmd_rdy;
    clr_uart_nxt    = 1'b0;
    tour_ack_nxt    = 1'b0;
    tour_active_nxt = tour_active;
    resp_nxt        = resp;
    resp_snd_nxt    = 1'b0;
    resp_pend_nxt   = 1'b0;
    uart_done       = 1'b0;
    abort_fire      = 1'b0;

    // tour_ack / clr_uart_cmd_rdy still high means the requester has not yet dropped its ready
    unique case (state)
      IDLE: begin
        if (tour_active && tour_cmd_rdy && !tour_ack) begin
          cmd_nxt     = tour_cmd;
          cmd_rdy_nxt = 1'b1;
          state_nxt   = GNT_T;
        end else if (!tour_active && uart_cmd_rdy && !clr_uart_cmd_rdy) begin
          cmd_nxt      = uart_cmd;
          cmd_rdy_nxt  = 1'b1;
          clr_uart_nxt = 1'b1;
          state_nxt    = GNT_U;
        end else if (abort_req) begin
          clr_uart_nxt = 1'b1;
          abort_fire   = 1'b1;
        end
      end
      GNT_U: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_nxt = 1'b0;
          state_nxt   = BUSY_U;
        end
      end
      BUSY_U: begin
        if (send_resp) begin
          uart_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      GNT_T: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_nxt = 1'b0;
          state_nxt   = BUSY_T;
        end
      end
      BUSY_T: begin
        if (send_resp) begin
          tour_ack_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (tour_go) tour_active_nxt = 1'b1;
    if (tour_done || abort_fire) tour_active_nxt = 1'b0;

    // tour-level responses go first; a colliding UART ack is held one cycle
    if (tour_done) begin
      resp_snd_nxt  = 1'b1;
      resp_nxt      = RESP_ACK;
      resp_pend_nxt = uart_done || resp_pend;
    end else if (abort_fire) begin
      resp_snd_nxt  = 1'b1;
      resp_nxt      = RESP_ABORT;
      resp_pend_nxt = uart_done || resp_pend;
    end else if (uart_done || resp_pend) begin
      resp_snd_nxt = 1'b1;
      resp_nxt     = RESP_ACK;
    end
  end

endmodule

// File: tb/tb_cmd_arb.sv
// Self-checking bench for cmd_arb: directed scenarios plus randomized UART/tour traffic.
module tb_cmd_arb;

  localparam logic [7:0] ACK   = 8'hA5;
  localparam logic [7:0] ABORT = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] uart_cmd = '0;
  logic        uart_cmd_rdy = 1'b0;
  logic        clr_uart_cmd_rdy;
  logic [15:0] tour_cmd = '0;
  logic        tour_cmd_rdy = 1'b0;
  logic        tour_ack;
  logic        tour_go = 1'b0;
  logic        tour_done = 1'b0;
  logic        tour_active;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;
  logic        resp_snd;

  always #5 clk = ~clk;

  cmd_arb dut (
    .clk(clk), .rst_n(rst_n),
    .uart_cmd(uart_cmd), .uart_cmd_rdy(uart_cmd_rdy), .clr_uart_cmd_rdy(clr_uart_cmd_rdy),
    .tour_cmd(tour_cmd), .tour_cmd_rdy(tour_cmd_rdy), .tour_ack(tour_ack),
    .tour_go(tour_go), .tour_done(tour_done), .tour_active(tour_active),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp), .resp_snd(resp_snd)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] resp_q[$];
  int ack_exp = 0;
  int ack_seen = 0;
  bit tour_m = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // every response byte must match the next one the scenario promised
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_snd) begin
        chk("resp_expected", 16'(resp_q.size() != 0), 16'd1);
        if (resp_q.size() != 0) chk("resp_byte_order", 16'(resp), 16'(resp_q.pop_front()));
      end
      if (tour_ack) ack_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input int n, input string tag);
    repeat (n) begin
      tick();
      chk({tag, "_clr_uart"}, 16'(clr_uart_cmd_rdy), 16'd0);
      chk({tag, "_cmd_rdy"}, 16'(cmd_rdy), 16'd0);
    end
  endtask

  task automatic uart_accept(input logic [15:0] c);
    uart_cmd = c;
    uart_cmd_rdy = 1'b1;
    tick();
    chk("u_clr_uart", 16'(clr_uart_cmd_rdy), 16'd1);
    chk("u_cmd_rdy", 16'(cmd_rdy), 16'd1);
    chk("u_cmd", cmd, c);
    uart_cmd_rdy = 1'b0;
  endtask

  task automatic uart_finish(input logic [15:0] c, input bit early, input bit with_done);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("u_hold_rdy", 16'(cmd_rdy), 16'd1);
      chk("u_clr_uart_once", 16'(clr_uart_cmd_rdy), 16'd0);
    end
    if (early) begin
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      chk("u_early_no_resp", 16'(resp_snd), 16'd0);
      chk("u_early_rdy", 16'(cmd_rdy), 16'd1);
    end
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("u_rdy_drop", 16'(cmd_rdy), 16'd0);
    chk("u_clr_uart_low", 16'(clr_uart_cmd_rdy), 16'd0);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("u_busy_quiet", 16'(resp_snd), 16'd0);
    end
    send_resp = 1'b1;
    if (with_done) begin
      tour_done = 1'b1;
      resp_q.push_back(ACK);
      tour_m = 1'b0;
    end
    resp_q.push_back(ACK);
    tick();
    send_resp = 1'b0;
    tour_done = 1'b0;
    chk("u_resp_snd", 16'(resp_snd), 16'd1);
    chk("u_resp", 16'(resp), 16'(ACK));
    chk("u_no_tour_ack", 16'(tour_ack), 16'd0);
    chk("u_tour_active", 16'(tour_active), 16'(tour_m));
    if (with_done) begin
      tick();
      chk("u_delayed_resp_snd", 16'(resp_snd), 16'd1);
      chk("u_delayed_resp", 16'(resp), 16'(ACK));
    end
    tick();
    chk("u_resp_once", 16'(resp_snd), 16'd0);
    chk("u_cmd_hold", cmd, c);
    chk("u_idle_rdy", 16'(cmd_rdy), 16'd0);
  endtask

  task automatic tour_start();
    tour_go = 1'b1;
    tick();
    tour_go = 1'b0;
    tour_m = 1'b1;
    chk("t_active_set", 16'(tour_active), 16'd1);
  endtask

  task automatic tour_end();
    tour_done = 1'b1;
    resp_q.push_back(ACK);
    tick();
    tour_done = 1'b0;
    tour_m = 1'b0;
    chk("t_active_clr", 16'(tour_active), 16'd0);
    chk("t_done_resp_snd", 16'(resp_snd), 16'd1);
    chk("t_done_resp", 16'(resp), 16'(ACK));
  endtask

  task automatic tour_move(input logic [15:0] c);
    tour_cmd = c;
    tour_cmd_rdy = 1'b1;
    tick();
    chk("t_cmd_rdy", 16'(cmd_rdy), 16'd1);
    chk("t_cmd", cmd, c);
    chk("t_no_clr_uart", 16'(clr_uart_cmd_rdy), 16'd0);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("t_hold_rdy", 16'(cmd_rdy), 16'd1);
    end
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("t_rdy_drop", 16'(cmd_rdy), 16'd0);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("t_busy_quiet", 16'(tour_ack), 16'd0);
    end
    send_resp = 1'b1;
    ack_exp++;
    tick();
    send_resp = 1'b0;
    tour_cmd_rdy = 1'b0;
    chk("t_ack", 16'(tour_ack), 16'd1);
    chk("t_no_resp", 16'(resp_snd), 16'd0);
    tick();
    chk("t_ack_once", 16'(tour_ack), 16'd0);
    chk("t_cmd_hold", cmd, c);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd"}, cmd, 16'h0000);
    chk({tag, "_cmd_rdy"}, 16'(cmd_rdy), 16'd0);
    chk({tag, "_clr_uart"}, 16'(clr_uart_cmd_rdy), 16'd0);
    chk({tag, "_tour_ack"}, 16'(tour_ack), 16'd0);
    chk({tag, "_tour_active"}, 16'(tour_active), 16'd0);
    chk({tag, "_resp"}, 16'(resp), 16'd0);
    chk({tag, "_resp_snd"}, 16'(resp_snd), 16'd0);
  endtask

  initial begin
    logic [15:0] c;
    // reset values
    repeat (2) tick();
    chk_all_zero("rst");
    #2 rst_n = 1'b1;
    tick();

    // idle UART command
    uart_accept(16'h2000);
    uart_finish(16'h2000, 1'b0, 1'b0);

    // single tour move
    tour_start();
    tour_move(16'h4002);
    tour_end();

    // simultaneous requests: tour wins, UART waits for tour_done
    tour_start();
    uart_cmd = 16'h3001;
    uart_cmd_rdy = 1'b1;
    tour_move(16'h4105);
    idle_chk(2, "sim_pending");
    tour_end();
    uart_accept(16'h3001);
    uart_finish(16'h3001, 1'b0, 1'b0);

    // tour_done coinciding with a UART completion
    uart_accept(16'h5555);
    tour_start();
    uart_finish(16'h5555, 1'b0, 1'b1);

    // send_resp during GNT_U is ignored
    uart_accept(16'h6123);
    uart_finish(16'h6123, 1'b1, 1'b0);

    // reset in BUSY_U with a tour active
    uart_accept(16'h1234);
    tour_start();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    #2 rst_n = 1'b0;
    send_resp = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    send_resp = 1'b0;
    tour_m = 1'b0;
    tick();
    chk_all_zero("rst_hold");
    #2 rst_n = 1'b1;
    tick();
    uart_accept(16'h7abc);
    uart_finish(16'h7abc, 1'b0, 1'b0);

`ifdef CMD_ARB_ABORT_EN
    // abort from IDLE
    tour_start();
    uart_cmd = 16'hF000;
    uart_cmd_rdy = 1'b1;
    resp_q.push_back(ABORT);
    tick();
    uart_cmd_rdy = 1'b0;
    tour_m = 1'b0;
    chk("ab_clr_uart", 16'(clr_uart_cmd_rdy), 16'd1);
    chk("ab_no_cmd_rdy", 16'(cmd_rdy), 16'd0);
    chk("ab_active", 16'(tour_active), 16'd0);
    chk("ab_resp_snd", 16'(resp_snd), 16'd1);
    chk("ab_resp", 16'(resp), 16'(ABORT));
    idle_chk(2, "ab_after");
    // abort waits for an in-flight tour move
    tour_start();
    tour_cmd = 16'h4777;
    tour_cmd_rdy = 1'b1;
    tick();
    chk("abt_cmd_rdy", 16'(cmd_rdy), 16'd1);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    uart_cmd = 16'hF0AB;
    uart_cmd_rdy = 1'b1;
    repeat (2) begin
      tick();
      chk("abt_wait_clr", 16'(clr_uart_cmd_rdy), 16'd0);
      chk("abt_wait_active", 16'(tour_active), 16'd1);
    end
    send_resp = 1'b1;
    ack_exp++;
    tick();
    send_resp = 1'b0;
    tour_cmd_rdy = 1'b0;
    chk("abt_ack", 16'(tour_ack), 16'd1);
    chk("abt_clr_late", 16'(clr_uart_cmd_rdy), 16'd0);
    resp_q.push_back(ABORT);
    tick();
    uart_cmd_rdy = 1'b0;
    tour_m = 1'b0;
    chk("abt_clr_uart", 16'(clr_uart_cmd_rdy), 16'd1);
    chk("abt_resp", 16'(resp), 16'(ABORT));
    chk("abt_active", 16'(tour_active), 16'd0);
    chk("abt_cmd_hold", cmd, 16'h4777);
    idle_chk(2, "abt_after");
`else
    // opcode F is an ordinary command that waits for the tour to end
    tour_start();
    uart_cmd = 16'hF000;
    uart_cmd_rdy = 1'b1;
    idle_chk(3, "f_pending");
    chk("f_active", 16'(tour_active), 16'd1);
    tour_end();
    uart_accept(16'hF000);
    uart_finish(16'hF000, 1'b0, 1'b0);
`endif

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        c = 16'($urandom);
        uart_accept(c);
        uart_finish(c, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        tour_start();
        repeat ($urandom_range(1, 3)) tour_move(16'($urandom));
        tour_end();
      end
      idle_chk($urandom_range(0, 2), "rnd_gap");
    end

    tick();
    chk("resp_q_drained", 16'(resp_q.size()), 16'd0);
    chk("tour_ack_count", 16'(ack_seen), 16'(ack_exp));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
